// File: rtl/spi_slave_burst_xfer_if.sv
// SPI pins plus the burst request/data handshake of spi_slave_burst_xfer,
// grouped so the slave and its driving master share one bundle.
interface spi_slave_burst_xfer_if #(
  parameter int DATA_W = 8
);
  logic              spi_sck_p;
  logic              spi_mosi_p;
  logic              spi_miso_p;
  logic              init_transfer_p;
  logic [7:0]        burst_len_p;
  logic [DATA_W-1:0] tx_data_p;
  logic              tx_load_p;
  logic [DATA_W-1:0] rx_data_p;
  logic              rx_valid_p;
  logic              busy_p;
  logic              transfer_done_p;

  modport slave (
    input  spi_sck_p, spi_mosi_p, init_transfer_p, burst_len_p, tx_data_p,
    output spi_miso_p, tx_load_p, rx_data_p, rx_valid_p, busy_p, transfer_done_p
  );

  modport master (
    output spi_sck_p, spi_mosi_p, init_transfer_p, burst_len_p, tx_data_p,
    input  spi_miso_p, tx_load_p, rx_data_p, rx_valid_p, busy_p, transfer_done_p
  );
endinterface

// File: rtl/spi_slave_burst_xfer.sv
// SPI slave that moves a burst of DATA_W-bit words per init_transfer_p request.
// Define SPI_SLAVE_ABORT_EN to let init_transfer_p low abort a burst in flight.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for init_transfer_p; MISO parked high
// LOAD       | capturing the next tx word (tx_load_p high)
// WAIT_LEAD  | waiting for the leading SCK edge of the current bit
// WAIT_TRAIL | waiting for the trailing SCK edge of the current bit
// DONE       | burst finished; transfer_done_p held until init drops
module spi_slave_burst_xfer #(
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic                   clk_p,
  input  logic                   rst_p,
  spi_slave_burst_xfer_if.slave  bus
);

  localparam int            BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          SCK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_LEAD,
    WAIT_TRAIL,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              sck_s0_q, sck_s1_q;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]        word_cnt_q, word_cnt_d;
  logic [8:0]        len_q, len_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic last_bit, last_word, abort;

  assign sck_rise   = ~sck_s1_q & sck_s0_q;
  assign sck_fall   = sck_s1_q & ~sck_s0_q;
  assign lead_edge  = (CPOL == 0) ? sck_rise : sck_fall;
  assign trail_edge = (CPOL == 0) ? sck_fall : sck_rise;
  assign last_bit   = (bit_cnt_q == LAST_BIT);
  assign last_word  = (word_cnt_q == (len_q - 9'd1));

`ifdef SPI_SLAVE_ABORT_EN
  assign abort = ~bus.init_transfer_p;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      sck_s0_q <= SCK_IDLE;
      sck_s1_q <= SCK_IDLE;
    end else begin
      sck_s0_q <= bus.spi_sck_p;
      sck_s1_q <= sck_s0_q;
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (bus.init_transfer_p) begin
          len_d      = (bus.burst_len_p == 8'd0) ? 9'd256 : {1'b0, bus.burst_len_p};
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        // CPHA=0 needs the MSB on the wire before the first leading edge
        if (CPHA == 0) begin
          miso_d  = bus.tx_data_p[DATA_W-1];
          tx_sr_d = bus.tx_data_p << 1;
        end else begin
          tx_sr_d = bus.tx_data_p;
        end
        state_d = WAIT_LEAD;
      end

      WAIT_LEAD: begin
        if (lead_edge) begin
          if (CPHA == 0) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.spi_mosi_p};
            if (last_bit) begin
              rx_data_d  = rx_sr_d;
              rx_valid_d = 1'b1;
            end
          end else begin
            miso_d  = tx_sr_q[DATA_W-1];
            tx_sr_d = tx_sr_q << 1;
          end
          state_d = WAIT_TRAIL;
        end
      end

      WAIT_TRAIL: begin
        if (trail_edge) begin
          if (CPHA == 0) begin
            if (!last_bit) begin
              miso_d  = tx_sr_q[DATA_W-1];
              tx_sr_d = tx_sr_q << 1;
            end
          end else begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.spi_mosi_p};
            if (last_bit) begin
              rx_data_d  = rx_sr_d;
              rx_valid_d = 1'b1;
            end
          end
          if (last_bit) begin
            bit_cnt_d = '0;
            if (last_word) begin
              miso_d  = 1'b1;
              state_d = DONE;
            end else begin
              word_cnt_d = word_cnt_q + 9'd1;
              state_d    = LOAD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = WAIT_LEAD;
          end
        end
      end

      DONE: begin
        miso_d = 1'b1;
        if (!bus.init_transfer_p) begin
          state_d = IDLE;
        end
      end

      default: begin
        miso_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    // an abort drops the partial word, including a final sample landing this cycle
    if (abort && (state_q == LOAD || state_q == WAIT_LEAD || state_q == WAIT_TRAIL)) begin
      state_d    = IDLE;
      miso_d     = 1'b1;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
    end
  end

  assign bus.spi_miso_p      = miso_q;
  assign bus.tx_load_p       = (state_q == LOAD);
  assign bus.rx_data_p       = rx_data_q;
  assign bus.rx_valid_p      = rx_valid_q;
  assign bus.busy_p          = (state_q != IDLE);
  assign bus.transfer_done_p = (state_q == DONE);

endmodule
